display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexing controller that shares a single BCD-to-7-segment decoder between several common-cathode/anode digit positions of the clock display. It snapshots the packed BCD digit vector once per frame and scans digit positions in a fixed order. For each position it drives the decoder's `bcd`/`en` inputs and a one-hot digit-select, with a blanking guard interval between digits to prevent ghosting. It also applies leading-zero suppression and per-digit blinking (for the time-set mode) by deasserting the decoder enable.

## Interface
- `DIGITS`, default 6: number of digit positions; legal range 2..8; index 0 is least significant.
- `DWELL_CYCLES`, default 1024: clock cycles each digit is shown; must be >= 1.
- `BLANK_CYCLES`, default 4: guard cycles with all digits off before each digit; must be >= 1.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `digits_bcd`  in  4*DIGITS  packed BCD; digit i at bits [4i+3:4i].
- `digit_en`  in  DIGITS  per-digit enable; 0 = always blank that digit.
- `blink_mask`  in  DIGITS  digits that blink while the blink phase is 1.
- `blink_tick`  in  1  single-cycle pulse; toggles the blink phase.
- `lz_suppress`  in  1  1 = blank leading zeros.
- `bcd`  out  4  digit value to the decoder.
- `bcd_en`  out  1  decoder enable; 0 makes the decoder output all segments off.
- `digit_sel`  out  DIGITS  one-hot active-high digit select; all-zero during blanking.
- `frame_start`  out  1  high for the first cycle of each frame.

## Operation
- Two-state FSM: BLANK and SHOW. A scan index `idx` runs 0..DIGITS-1, and a dwell counter `cnt` is sized to max(DWELL_CYCLES, BLANK_CYCLES).
- BLANK: `digit_sel`=0, `bcd_en`=0, `bcd`=0. The FSM stays for BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1), then goes to SHOW with cnt=0.
- SHOW: `digit_sel`=1<<idx and `bcd`=snapshot digit idx. The FSM stays for DWELL_CYCLES cycles, then goes to BLANK with cnt=0 and idx+1. After idx DIGITS-1, idx wraps to 0.
- Snapshot: `digits_bcd`, `digit_en`, `blink_mask` and `lz_suppress` are registered at the end of the first BLANK cycle of idx 0, which is the `frame_start` cycle. Input changes mid-frame have no visible effect until the next frame.
- Leading-zero flag for digit i: lz_suppress_snap=1, i != 0, and every snapshot digit from i up to DIGITS-1 equals 0. Digit 0 is never suppressed.
- `bcd_en` in SHOW = digit_en_snap[idx] AND NOT leading-zero flag AND NOT (blink_phase AND blink_mask_snap[idx]).
- `bcd` still carries the snapshot value when `bcd_en`=0 in SHOW, and `digit_sel` stays asserted.
- blink_phase: 1-bit register that toggles on every cycle `blink_tick`=1. It is not snapshotted, so it takes effect on the next cycle.
- Non-BCD digit values (A-F) are passed through unchanged; the decoder blanks them.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset (async assert) values: state=BLANK, idx=0, cnt=0, blink_phase=0, snapshot=0, `digit_sel`=0, `bcd_en`=0, `bcd`=0.
- `frame_start`=1 in the first cycle after reset release, because the reset state is the frame-start condition.
- Frame period = DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. `frame_start` is a single-cycle pulse with exactly that period.
- Digit i SHOW begins i*(B+D)+B cycles after `frame_start` (B = BLANK_CYCLES, D = DWELL_CYCLES).
- Snapshot latency: an input change is displayed from the next `frame_start`+B cycles onward.
- `blink_tick` on consecutive cycles toggles the phase each cycle.
- Reset mid-SHOW: `digit_sel` drops to 0 immediately (asynchronously), and the scan restarts at BLANK idx 0.
- `digit_sel` is never multi-hot. A BLANK gap of at least 1 cycle with `digit_sel`=0 separates every pair of SHOW windows, including across the wrap from idx DIGITS-1 to 0.

## Test plan
- Scan order: DIGITS=4, D=4, B=2, digits_bcd=16'h4321, all enables 1, lz off. Required response: digit_sel 0,1,2,4,8 pattern with 2 zero cycles before each digit; bcd 1,2,3,4 over 4 cycles each; frame_start every 24 cycles.
- Leading zeros: digits_bcd=16'h0050, lz_suppress=1 → bcd_en=0 for idx 3 and 2, 1 for idx 1 and 0. With digits_bcd=16'h0000, only idx 0 is enabled.
- Blink: blink_mask=4'b0011, one blink_tick pulse → idx 0,1 get bcd_en=0 and idx 2,3 stay 1. A second pulse restores all four.
- Snapshot: change digits_bcd from 16'h1111 to 16'h9999 during idx 1 SHOW → rest of frame shows 1s; the next frame shows 9s.
- Reset mid-operation: assert rst_n=0 during idx 2 SHOW → digit_sel=0, bcd_en=0 without a clock edge. After release, frame_start=1 in the first cycle and idx 0 SHOW starts 2 cycles later.
- digit_en=4'b1010 → bcd_en=0 in SHOW for idx 0 and 2 while digit_sel still steps one-hot.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed digit scanner that shares one BCD-to-7-segment decoder.
// Revision 1.0 - initial release.
`default_nettype none

module display_scan_ctrl #(
  parameter int DIGITS       = 6,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blink_tick,
  input  logic                  lz_suppress,
  output logic [3:0]            bcd,
  output logic                  bcd_en,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_ONE    = DIGITS'(1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               blink_phase;

  logic [3:0]         snap_digit [DIGITS];
  logic [DIGITS-1:0]  snap_en;
  logic [DIGITS-1:0]  snap_blink;
  logic               snap_lz;

  logic               frame_pulse;
  logic [DIGITS-1:1]  zero_upto;
  logic [DIGITS-1:0]  lz_flag;

  // The reset state is itself the frame-start condition.
  assign frame_pulse = (state == ST_BLANK) && (idx == '0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BLANK;
      idx         <= '0;
      cnt         <= '0;
      blink_phase <= 1'b0;
      snap_en     <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        snap_digit[i] <= 4'd0;
      end
    end else begin
      if (blink_tick) begin
        blink_phase <= ~blink_phase;
      end

      if (frame_pulse) begin
        snap_en    <= digit_en;
        snap_blink <= blink_mask;
        snap_lz    <= lz_suppress;
        for (int i = 0; i < DIGITS; i++) begin
          snap_digit[i] <= digits_bcd[4*i +: 4];
        end
      end

      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // zero_upto[i]: snapshot digits i..DIGITS-1 are all zero.
  for (genvar i = 1; i < DIGITS; i++) begin : g_lz
    if (i == DIGITS - 1) begin : g_top
      assign zero_upto[i] = (snap_digit[i] == 4'd0);
    end else begin : g_mid
      assign zero_upto[i] = (snap_digit[i] == 4'd0) && zero_upto[i+1];
    end
    assign lz_flag[i] = snap_lz && zero_upto[i];
  end
  assign lz_flag[0] = 1'b0;

  always_comb begin
    digit_sel = '0;
    bcd       = 4'd0;
    bcd_en    = 1'b0;
    if (state == ST_SHOW) begin
      digit_sel = SEL_ONE << idx;
      bcd       = snap_digit[idx];
      bcd_en    = snap_en[idx] && !lz_flag[idx] && !(blink_phase && snap_blink[idx]);
    end
  end

  assign frame_start = frame_pulse;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIGITS=4, DWELL=4, BLANK=2 (24-cycle frame).
`default_nettype none

module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int D      = 4;
  localparam int B      = 2;
  localparam int FRAME  = DIGITS * (B + D);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic        blink_tick;
  logic        lz_suppress;
  logic [3:0]  bcd;
  logic        bcd_en;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int tests = 0;
  int fails = 0;

  display_scan_ctrl #(
    .DIGITS      (DIGITS),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_bcd (digits_bcd),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .blink_tick (blink_tick),
    .lz_suppress(lz_suppress),
    .bcd        (bcd),
    .bcd_en     (bcd_en),
    .digit_sel  (digit_sel),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    blink_tick = 1'b0;
  endtask

  // Checks one full frame starting at its frame_start cycle; optionally
  // rewrites digits_bcd at position chg_pos to probe snapshot isolation.
  task automatic run_frame(input string name, input logic [15:0] vals,
                           input logic [3:0] en_exp, input int chg_pos,
                           input logic [15:0] chg_val);
    for (int p = 0; p < FRAME; p++) begin
      int i;
      int w;
      logic [3:0] e_sel;
      logic [3:0] e_bcd;
      logic       e_en;
      i = p / (B + D);
      w = p % (B + D);
      if (w < B) begin
        e_sel = 4'b0000;
        e_bcd = 4'd0;
        e_en  = 1'b0;
      end else begin
        e_sel = 4'b0001 << i;
        e_bcd = vals[4*i +: 4];
        e_en  = en_exp[i];
      end
      chk({name, ".sel"}, 32'(digit_sel), 32'(e_sel));
      chk({name, ".bcd"}, 32'(bcd), 32'(e_bcd));
      chk({name, ".en"},  32'(bcd_en), 32'(e_en));
      chk({name, ".fs"},  32'(frame_start), 32'(p == 0));
      if (p == chg_pos) digits_bcd = chg_val;
      step();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    digits_bcd  = 16'h4321;
    digit_en    = 4'b1111;
    blink_mask  = 4'b0000;
    blink_tick  = 1'b0;
    lz_suppress = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.sel", 32'(digit_sel), 32'h0);
    chk("rst.en",  32'(bcd_en), 32'h0);
    chk("rst.bcd", 32'(bcd), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Scan order and frame period
    run_frame("scan", 16'h4321, 4'b1111, -1, 16'h0);

    // Leading-zero suppression
    digits_bcd  = 16'h0050;
    lz_suppress = 1'b1;
    run_frame("lz50", 16'h0050, 4'b0011, -1, 16'h0);
    digits_bcd  = 16'h0000;
    run_frame("lz00", 16'h0000, 4'b0001, -1, 16'h0);

    // Blink: one pulse blanks masked digits, a second restores them
    lz_suppress = 1'b0;
    digits_bcd  = 16'h1234;
    blink_mask  = 4'b0011;
    blink_tick  = 1'b1;
    run_frame("blk1", 16'h1234, 4'b1100, -1, 16'h0);
    blink_tick  = 1'b1;
    run_frame("blk0", 16'h1234, 4'b1111, -1, 16'h0);

    // Per-digit enable and non-BCD passthrough
    blink_mask  = 4'b0000;
    digit_en    = 4'b1010;
    digits_bcd  = 16'hF0A7;
    run_frame("den", 16'hF0A7, 4'b1010, -1, 16'h0);

    // Snapshot isolation: change lands during idx 1 SHOW
    digit_en    = 4'b1111;
    digits_bcd  = 16'h1111;
    run_frame("snapA", 16'h1111, 4'b1111, 9, 16'h9999);
    run_frame("snapB", 16'h9999, 4'b1111, -1, 16'h0);

    // Asynchronous reset during idx 2 SHOW
    repeat (2 * (B + D) + B) step();
    chk("pre_rst.sel", 32'(digit_sel), 32'h4);
    chk("pre_rst.en",  32'(bcd_en), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.sel", 32'(digit_sel), 32'h0);
    chk("arst.en",  32'(bcd_en), 32'h0);
    chk("arst.bcd", 32'(bcd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_frame("post", 16'h9999, 4'b1111, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
